// File: rtl/rmst_in_fm_ctrl_if.sv
// -----------------------------------------------------------------------------
// rmst_in_fm_ctrl_if
// Control bundle between the input-FM load controller and its surroundings
// (load sequencer, Avalon read master, load FIFO).
//   master : the controller side (rmst_in_fm_ctrl)
//   slave  : sequencer / read master / FIFO side
// Signals
//   load_start            tile fetch request pulse
//   load_done             tile fetch complete pulse
//   tile_base_n/row/col   tile origin (channel, row, col)
//   param_raddr           burst start byte address
//   param_iolen           burst length in words
//   load_trans_start      burst start pulse to the read master
//   load_trans_done       burst finished pulse from the read master
//   load_fifo_almost_full FIFO cannot take another full row burst
// -----------------------------------------------------------------------------
interface rmst_in_fm_ctrl_if #(
  parameter int CW  = 16,
  parameter int XAW = 32
) ();
  logic           load_start;
  logic           load_done;
  logic [CW-1:0]  tile_base_n;
  logic [CW-1:0]  tile_base_row;
  logic [CW-1:0]  tile_base_col;
  logic [XAW-1:0] param_raddr;
  logic [CW-1:0]  param_iolen;
  logic           load_trans_start;
  logic           load_trans_done;
  logic           load_fifo_almost_full;

  modport master (
    input  load_start, tile_base_n, tile_base_row, tile_base_col,
           load_trans_done, load_fifo_almost_full,
    output load_done, param_raddr, param_iolen, load_trans_start
  );

  modport slave (
    output load_start, tile_base_n, tile_base_row, tile_base_col,
           load_trans_done, load_fifo_almost_full,
    input  load_done, param_raddr, param_iolen, load_trans_start
  );
endinterface

// File: rtl/rmst_in_fm_ctrl.sv
// -----------------------------------------------------------------------------
// rmst_in_fm_ctrl
// Drives the Avalon read master that fetches one input feature-map tile
// (Tn channels x Tr rows x Tc cols) from DDR into the load FIFO. One row burst
// is issued per (channel, row) pair, rows of a channel first, then the next
// channel. The tile is clipped at the N/R/C borders and FIFO back-pressure is
// honoured between bursts (never inside one).
// Ports
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : rmst_in_fm_ctrl_if.master (start/done handshake, tile origin,
//          burst parameters, burst start/done, FIFO almost-full)
// -----------------------------------------------------------------------------
module rmst_in_fm_ctrl #(
  parameter int AW         = 12,  // internal mem addr width, not used by this block
  parameter int CW         = 16,
  parameter int DW         = 32,
  parameter int XAW        = 32,
  parameter int XDW        = 128,
  parameter int N          = 32,
  parameter int R          = 64,
  parameter int C          = 32,
  parameter int K          = 3,
  parameter int S          = 1,
  parameter int Tn         = 16,
  parameter int Tr         = 64,
  parameter int Tc         = 16,
  parameter int IN_FM_BASE = 0
) (
  input  logic             clk,
  input  logic             rst,
  rmst_in_fm_ctrl_if.master bus
);

  if (AW < 1 || DW < 1 || XDW % DW != 0 || K < 1 || S < 1 || CW < 2 || XAW < 3)
  begin : g_param_check
    $error("rmst_in_fm_ctrl: inconsistent parameters");
  end

  localparam logic [CW-1:0]  N_B     = CW'(N);
  localparam logic [CW-1:0]  R_B     = CW'(R);
  localparam logic [CW-1:0]  C_B     = CW'(C);
  localparam logic [CW-1:0]  TN_B    = CW'(Tn);
  localparam logic [CW-1:0]  TR_B    = CW'(Tr);
  localparam logic [CW-1:0]  TC_B    = CW'(Tc);
  localparam logic [XAW-1:0] RC_X    = XAW'(R * C);
  localparam logic [XAW-1:0] C_X     = XAW'(C);
  localparam logic [XAW-1:0] BASE_X  = XAW'(IN_FM_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CONFIG,
    S_TRANS,
    S_DONE
  } state_t;

  state_t         state, state_nxt;

  logic [CW-1:0]  base_n, base_row, base_col;
  logic [CW-1:0]  n_len, row_len, col_len;
  logic [CW-1:0]  tn, tr;
  logic           last;
  logic [XAW-1:0] raddr_q;
  logic [CW-1:0]  iolen_q;
  logic           trans_start_q, done_q;
  logic           trans_start_d, done_d;

  // Length of the tile along one axis, clipped at the feature-map border.
  function automatic logic [CW-1:0] clip_len(input logic [CW-1:0] base,
                                             input logic [CW-1:0] bound,
                                             input logic [CW-1:0] tile);
    logic [CW-1:0] rem;
    if (base >= bound) return '0;
    rem = bound - base;
    return (rem < tile) ? rem : tile;
  endfunction

  logic [CW-1:0]  n_len_in, row_len_in, col_len_in;
  logic           zero_len, start_ok, step, row_end, tile_end;
  logic [XAW-1:0] word_addr;

  assign n_len_in   = clip_len(bus.tile_base_n,   N_B, TN_B);
  assign row_len_in = clip_len(bus.tile_base_row, R_B, TR_B);
  assign col_len_in = clip_len(bus.tile_base_col, C_B, TC_B);
  assign zero_len   = (n_len_in == '0) || (row_len_in == '0) || (col_len_in == '0);

  assign start_ok = (state == S_IDLE) && bus.load_start;
  assign step     = (state == S_TRANS) && bus.load_trans_done;
  assign row_end  = (tr == row_len - CW'(1));
  assign tile_end = row_end && (tn == n_len - CW'(1));

  // Word address of the current row; widened to XAW before any arithmetic so
  // the channel*R*C product cannot wrap at CW bits.
  assign word_addr = BASE_X
                   + (XAW'(base_n)   + XAW'(tn)) * RC_X
                   + (XAW'(base_row) + XAW'(tr)) * C_X
                   + XAW'(base_col);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (bus.load_start) state_nxt = zero_len ? S_DONE : S_WAIT;
      S_WAIT:   if (!bus.load_fifo_almost_full) state_nxt = S_CONFIG;
      S_CONFIG: state_nxt = S_TRANS;
      S_TRANS:  if (bus.load_trans_done) state_nxt = S_DONE;
      S_DONE:   state_nxt = last ? S_IDLE : S_WAIT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered below so both pulses are glitch-free)
  // ---------------------------------------------------------------------------
  always_comb begin
    trans_start_d = (state == S_CONFIG);
    done_d        = (state == S_DONE) && last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trans_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      trans_start_q <= trans_start_d;
      done_q        <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Tile bookkeeping and burst parameters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_n   <= '0;
      base_row <= '0;
      base_col <= '0;
      n_len    <= '0;
      row_len  <= '0;
      col_len  <= '0;
      tn       <= '0;
      tr       <= '0;
      last     <= 1'b0;
      raddr_q  <= '0;
      iolen_q  <= '0;
    end else begin
      if (start_ok) begin
        base_n   <= bus.tile_base_n;
        base_row <= bus.tile_base_row;
        base_col <= bus.tile_base_col;
        n_len    <= n_len_in;
        row_len  <= row_len_in;
        col_len  <= col_len_in;
        tn       <= '0;
        tr       <= '0;
        // An empty tile goes straight to DONE and must finish there.
        last     <= zero_len;
      end else if (step) begin
        if (row_end) begin
          tr <= '0;
          tn <= tn + CW'(1);
        end else begin
          tr <= tr + CW'(1);
        end
        if (tile_end) last <= 1'b1;
      end else if (done_d) begin
        last <= 1'b0;
      end

      // Burst parameters are captured once per burst and held until the next.
      if (state == S_CONFIG) begin
        raddr_q <= word_addr << 2;
        iolen_q <= col_len;
      end
    end
  end

  assign bus.param_raddr      = raddr_q;
  assign bus.param_iolen      = iolen_q;
  assign bus.load_trans_start = trans_start_q;
  assign bus.load_done        = done_q;

endmodule
